// File: rtl/sample_front_end_if.sv
// ---------------------------------------------------------------------------
// sample_front_end_if
//   Bundles the sample-side signals of sample_front_end: the raw sample
//   source (asynchronous fs_in, valid_in, u_in, d_in) and the captured,
//   clk-domain results that feed LMS_filter.
//
//   Parameters : W      sample word width
//                CNT_W  period counter width (present only with
//                       SFE_PERIOD_OUT_EN defined)
//   Signals    : fs_in       sample clock, async to clk, both edges count
//                valid_in    source valid, sampled with the data
//                u_in/d_in   reference / primary sample words
//                u_out/d_out captured sample words
//                sample_stb  one-cycle new-sample pulse
//                valid_out   locked and source-valid qualifier
//                mode_out    locked rate, 0 slow / 1 fast
//                per_out     last measured period (SFE_PERIOD_OUT_EN only)
//   Modports   : master  sample source / consumer side
//                slave   sample_front_end side
// ---------------------------------------------------------------------------
interface sample_front_end_if #(
    parameter int W = 16
`ifdef SFE_PERIOD_OUT_EN
    , parameter int CNT_W = 13
`endif
);
    logic         fs_in;
    logic         valid_in;
    logic [W-1:0] u_in;
    logic [W-1:0] d_in;
    logic [W-1:0] u_out;
    logic [W-1:0] d_out;
    logic         sample_stb;
    logic         valid_out;
    logic         mode_out;
`ifdef SFE_PERIOD_OUT_EN
    logic [CNT_W-1:0] per_out;

    modport master (
        output fs_in, valid_in, u_in, d_in,
        input  u_out, d_out, sample_stb, valid_out, mode_out, per_out
    );
    modport slave (
        input  fs_in, valid_in, u_in, d_in,
        output u_out, d_out, sample_stb, valid_out, mode_out, per_out
    );
`else
    modport master (
        output fs_in, valid_in, u_in, d_in,
        input  u_out, d_out, sample_stb, valid_out, mode_out
    );
    modport slave (
        input  fs_in, valid_in, u_in, d_in,
        output u_out, d_out, sample_stb, valid_out, mode_out
    );
`endif
endinterface

// File: rtl/sample_front_end.sv
// ---------------------------------------------------------------------------
// sample_front_end
//   Upstream stage of LMS_filter. Synchronizes the asynchronous sample clock
//   fs_in into clk, treats every fs_in edge as a new sample, captures the
//   u/d words with a one-cycle strobe, measures the edge-to-edge period to
//   classify the rate and qualifies the samples with a lock/timeout FSM.
//
//   Ports : clk   system clock
//           nrst  asynchronous reset, active low
//           sif   sample_front_end_if.slave (fs_in, valid_in, u_in, d_in in;
//                 u_out, d_out, sample_stb, valid_out, mode_out out)
//
//   Optional: define SFE_PERIOD_OUT_EN to add sif.per_out, the period latched
//   with the most recent sample_stb (rate diagnostics).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset; first edge has no valid period, no strobe
//   ACQ   | classifying periods, counting agreeing classifications
//   LOCK  | rate locked, valid_out follows the source valid
//   LOST  | no edge for TIMEOUT cycles; next edge restarts acquisition
// ---------------------------------------------------------------------------
module sample_front_end #(
    parameter int W       = 16,
    parameter int CNT_W   = 13,
    parameter int THRESH  = 2175,
    parameter int TIMEOUT = 4096,
    parameter int LOCK_N  = 4
) (
    input  logic               clk,
    input  logic               nrst,
    sample_front_end_if.slave  sif
);

    localparam int               AGR_W     = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [AGR_W-1:0] LOCK_N_C  = AGR_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        LOST = 2'd3
    } state_t;

    logic             fs_s1_q, fs_s2_q, fs_s3_q;
    logic             fs_edge;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cls;
    logic             timeout;
    state_t           state_q, state_d;
    logic             cand_q, cand_d;
    logic [AGR_W-1:0] agree_q, agree_d;
    logic             mode_q, mode_d;
    logic             stb_q, stb_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     u_q, d_q;
`ifdef SFE_PERIOD_OUT_EN
    logic [CNT_W-1:0] per_q;
`endif

    assign fs_edge = fs_s2_q ^ fs_s3_q;
    // The counter value at the edge cycle is the period just ended.
    assign cls     = (cnt_q < THRESH_C);
    assign timeout = (cnt_q == TIMEOUT_C);

    always_comb begin
        cnt_d = cnt_q;
        if (fs_edge) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        agree_d = agree_q;
        mode_d  = mode_q;
        stb_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fs_edge) begin
                    state_d = ACQ;
                    agree_d = '0;
                end
            end
            ACQ: begin
                if (fs_edge) begin
                    stb_d = 1'b1;
                    if (cls == cand_q) begin
                        agree_d = agree_q + 1'b1;
                    end else begin
                        cand_d  = cls;
                        agree_d = AGR_W'(1);
                    end
                    if (agree_d == LOCK_N_C) begin
                        mode_d  = cand_d;
                        state_d = LOCK;
                    end
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            LOCK: begin
                if (fs_edge) begin
                    stb_d = 1'b1;
                    // mode_out keeps the old rate until a relock.
                    if (cls != mode_q) begin
                        state_d = ACQ;
                        cand_d  = cls;
                        agree_d = AGR_W'(1);
                    end
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                // The saturated period of this edge is not classified.
                if (fs_edge) begin
                    stb_d   = 1'b1;
                    state_d = ACQ;
                    agree_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // valid_out drops on the very edge the FSM leaves LOCK, otherwise it only
    // moves together with the strobe.
    always_comb begin
        valid_d = valid_q;
        if (state_d != LOCK) begin
            valid_d = 1'b0;
        end else if (stb_d) begin
            valid_d = sif.valid_in;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fs_s1_q <= 1'b0;
            fs_s2_q <= 1'b0;
            fs_s3_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
            cand_q  <= 1'b0;
            agree_q <= '0;
            mode_q  <= 1'b0;
            stb_q   <= 1'b0;
            valid_q <= 1'b0;
            u_q     <= '0;
            d_q     <= '0;
`ifdef SFE_PERIOD_OUT_EN
            per_q   <= '0;
`endif
        end else begin
            fs_s1_q <= sif.fs_in;
            fs_s2_q <= fs_s1_q;
            fs_s3_q <= fs_s2_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            cand_q  <= cand_d;
            agree_q <= agree_d;
            mode_q  <= mode_d;
            stb_q   <= stb_d;
            valid_q <= valid_d;
            if (stb_d) begin
                u_q <= sif.u_in;
                d_q <= sif.d_in;
`ifdef SFE_PERIOD_OUT_EN
                per_q <= cnt_q;
`endif
            end
        end
    end

    assign sif.u_out      = u_q;
    assign sif.d_out      = d_q;
    assign sif.sample_stb = stb_q;
    assign sif.valid_out  = valid_q;
    assign sif.mode_out   = mode_q;
`ifdef SFE_PERIOD_OUT_EN
    assign sif.per_out    = per_q;
`endif

endmodule

// File: tb/tb_sample_front_end.sv
// ---------------------------------------------------------------------------
// tb_sample_front_end
//   Directed bench for sample_front_end. Each fs_in edge pushes the sample it
//   should produce (data, valid_out, mode_out) into a scoreboard; a monitor
//   pops and compares on every sample_stb. Level checks cover reset, lock
//   loss and mid-run reset.
// ---------------------------------------------------------------------------
module tb_sample_front_end;

    localparam int SLOW_HALF = 22675;
    localparam int FAST_HALF = 20830;

    typedef struct {
        logic [15:0] u;
        logic [15:0] d;
        logic        vld;
        logic        mode;
        int          id;
    } exp_t;

    logic clk;
    logic nrst;
    int   n_pass = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t e;

    sample_front_end_if #(.W(16)) sif ();

    sample_front_end #(
        .W(16), .CNT_W(13), .THRESH(2175), .TIMEOUT(4096), .LOCK_N(4)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .sif  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int id,
                         input logic [31:0] obs, input logic [31:0] exp_v);
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (edge %0d): observed %0h, expected %0h", tag, id, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sif.sample_stb === 1'b1) begin
            check("stb_expected", -1, 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("u_out",     e.id, 32'(sif.u_out),     32'(e.u));
                check("d_out",     e.id, 32'(sif.d_out),     32'(e.d));
                check("valid_out", e.id, 32'(sif.valid_out), 32'(e.vld));
                check("mode_out",  e.id, 32'(sif.mode_out),  32'(e.mode));
            end
        end
    end

    task automatic step(input int pre_ns, input int n, input bit exp_stb,
                        input logic exp_vld, input logic exp_mode, input logic vin);
        #(pre_ns);
        sif.u_in     = 16'h1000 + 16'(n);
        sif.d_in     = 16'hA000 + 16'(n);
        sif.valid_in = vin;
        sif.fs_in    = ~sif.fs_in;
        if (exp_stb)
            sb_q.push_back(exp_t'{16'h1000 + 16'(n), 16'hA000 + 16'(n), exp_vld, exp_mode, n});
        #100;
        check("stb_seen", n, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic step_lat(input int pre_ns, input int n);
        longint t0;
        int     el;
        #(pre_ns);
        sif.u_in     = 16'h1234;
        sif.d_in     = 16'hABCD;
        sif.valid_in = 1'b1;
        sif.fs_in    = ~sif.fs_in;
        sb_q.push_back(exp_t'{16'h1234, 16'hABCD, 1'b1, 1'b0, n});
        t0 = longint'($time);
        @(posedge clk); #1;
        check("lat_k_stb",   n, 32'(sif.sample_stb), 32'd0);
        @(posedge clk); #1;
        check("lat_k1_stb",  n, 32'(sif.sample_stb), 32'd0);
        @(posedge clk); #1;
        check("lat_k2_stb",  n, 32'(sif.sample_stb), 32'd1);
        check("lat_k2_u",    n, 32'(sif.u_out),      32'h1234);
        check("lat_k2_d",    n, 32'(sif.d_out),      32'hABCD);
        @(posedge clk); #1;
        check("lat_k3_stb",  n, 32'(sif.sample_stb), 32'd0);
        el = int'(longint'($time) - t0);
        #(100 - el);
        check("stb_seen", n, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_u"},     -1, 32'(sif.u_out),      32'd0);
        check({tag, "_d"},     -1, 32'(sif.d_out),      32'd0);
        check({tag, "_stb"},   -1, 32'(sif.sample_stb), 32'd0);
        check({tag, "_valid"}, -1, 32'(sif.valid_out),  32'd0);
        check({tag, "_mode"},  -1, 32'(sif.mode_out),   32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst         = 1'b0;
        sif.fs_in    = 1'b0;
        sif.valid_in = 1'b0;
        sif.u_in     = '0;
        sif.d_in     = '0;
        #13;
        check_outputs_zero("reset");
        #10;
        nrst = 1'b1;

        // Slow rate: first edge leaves IDLE silently, lock on the 5th edge.
        step(1000,             1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(SLOW_HALF - 100,  2, 1'b1, 1'b0, 1'b0, 1'b1);
        step(SLOW_HALF - 100,  3, 1'b1, 1'b0, 1'b0, 1'b1);
        step(SLOW_HALF - 100,  4, 1'b1, 1'b0, 1'b0, 1'b1);
        step(SLOW_HALF - 100,  5, 1'b1, 1'b1, 1'b0, 1'b1);
        step(SLOW_HALF - 100,  6, 1'b1, 1'b1, 1'b0, 1'b1);
        step_lat(SLOW_HALF - 100, 7);

        // Source invalid for two samples, lock retained.
        step(SLOW_HALF - 100,  8, 1'b1, 1'b0, 1'b0, 1'b0);
        step(SLOW_HALF - 100,  9, 1'b1, 1'b0, 1'b0, 1'b0);
        check("invalid_hold_valid", 9, 32'(sif.valid_out), 32'd0);
        step(SLOW_HALF - 100, 10, 1'b1, 1'b1, 1'b0, 1'b1);
        check("relock_free_valid", 10, 32'(sif.valid_out), 32'd1);

        // Rate switch to fast: drop out of LOCK, mode held, relock fast.
        step(FAST_HALF - 100, 11, 1'b1, 1'b0, 1'b0, 1'b1);
        check("switch_mode_held", 11, 32'(sif.mode_out), 32'd0);
        step(FAST_HALF - 100, 12, 1'b1, 1'b0, 1'b0, 1'b1);
        step(FAST_HALF - 100, 13, 1'b1, 1'b0, 1'b0, 1'b1);
        step(FAST_HALF - 100, 14, 1'b1, 1'b1, 1'b1, 1'b1);
        step(FAST_HALF - 100, 15, 1'b1, 1'b1, 1'b1, 1'b1);
        step(FAST_HALF - 100, 16, 1'b1, 1'b1, 1'b1, 1'b1);

        // Mid-sample reset while locked fast (fs_in is low here).
        #9900;
        nrst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        #4;
        nrst = 1'b1;
        step(FAST_HALF - 100 - 9905, 17, 1'b0, 1'b0, 1'b0, 1'b1);
        step(FAST_HALF - 100, 18, 1'b1, 1'b0, 1'b0, 1'b1);
        step(FAST_HALF - 100, 19, 1'b1, 1'b0, 1'b0, 1'b1);
        step(FAST_HALF - 100, 20, 1'b1, 1'b0, 1'b0, 1'b1);
        step(FAST_HALF - 100, 21, 1'b1, 1'b1, 1'b1, 1'b1);

        // Loss of clock: still locked at 4000 cycles, lost by 4150.
        #39900;
        check("pre_timeout_valid", 21, 32'(sif.valid_out), 32'd1);
        check("pre_timeout_mode",  21, 32'(sif.mode_out),  32'd1);
        #1500;
        check("lost_valid", 21, 32'(sif.valid_out), 32'd0);
        check("lost_mode",  21, 32'(sif.mode_out),  32'd1);

        // Restart slow: unclassified first edge, relock after four more.
        step(1000,            22, 1'b1, 1'b0, 1'b1, 1'b1);
        step(SLOW_HALF - 100, 23, 1'b1, 1'b0, 1'b1, 1'b1);
        step(SLOW_HALF - 100, 24, 1'b1, 1'b0, 1'b1, 1'b1);
        step(SLOW_HALF - 100, 25, 1'b1, 1'b0, 1'b1, 1'b1);
        step(SLOW_HALF - 100, 26, 1'b1, 1'b1, 1'b0, 1'b1);
        check("final_valid", 26, 32'(sif.valid_out), 32'd1);
        check("final_mode",  26, 32'(sif.mode_out),  32'd0);

        #1000;
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
